// File: rtl/fp_addsub_pipe_pkg.sv
// Shared types and helpers for the pipelined floating-point adder/subtractor.
// Payload structs that depend on the exponent/mantissa widths are declared in
// the top module so they follow its parameters.
package fp_pkg;

  localparam int FP_EXP_W_DEF = 8;
  localparam int FP_MAN_W_DEF = 23;
  localparam int FP_TAG_W_DEF = 4;

  // Exception flags in output order {invalid, overflow, inexact}.
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic inexact;
  } fp_flags_t;

  typedef enum logic [2:0] {
    FP_ZERO = 3'd0,
    FP_SUB  = 3'd1,
    FP_NORM = 3'd2,
    FP_INF  = 3'd3,
    FP_QNAN = 3'd4,
    FP_SNAN = 3'd5
  } fp_class_e;

  // Result override decided during alignment and applied at the output.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_QNAN = 2'd1,
    SP_INF  = 2'd2
  } fp_special_e;

  // Width-independent classification from the decoded field summaries.
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_zero, input logic frac_msb);
    fp_class_e c;
    if (exp_ones) begin
      if (frac_zero) c = FP_INF;
      else if (frac_msb) c = FP_QNAN;
      else c = FP_SNAN;
    end else if (exp_zero) begin
      c = frac_zero ? FP_ZERO : FP_SUB;
    end else begin
      c = FP_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle of the FP add/sub unit.
interface fp_addsub_pipe_if
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  fp_flags_t        out_flags;

  // Issue logic / consumer side.
  modport master (
    output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_flags
  );

  // Arithmetic unit side.
  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_flags
  );
endinterface

// File: rtl/fp_addsub_pipe_lzc.sv
// Log-tree leading-zero counter; an all-zero input counts as WIDTH.
module fp_lzc #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH-1:0]           i_data,
  output logic [$clog2(WIDTH+1)-1:0] o_cnt
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int P     = 1 << CNT_W;

  // Trailing ones guarantee a hit, so a zero input yields exactly WIDTH.
  logic [P-1:0] w_pad;
  assign w_pad = {i_data, {(P-WIDTH){1'b1}}};

  for (genvar k = 0; k <= CNT_W; k++) begin : g_lvl
    localparam int N = P >> k;
    logic [N-1:0]     w_vld;
    logic [CNT_W-1:0] w_cnt [N];
    for (genvar i = 0; i < N; i++) begin : g_node
      if (k == 0) begin : g_leaf
        assign w_vld[i] = w_pad[P-1-i];
        assign w_cnt[i] = '0;
      end else begin : g_merge
        // Left child holds the more significant half of this node.
        assign w_vld[i] = g_lvl[k-1].w_vld[2*i] | g_lvl[k-1].w_vld[2*i+1];
        assign w_cnt[i] = g_lvl[k-1].w_vld[2*i] ? g_lvl[k-1].w_cnt[2*i]
                        : (g_lvl[k-1].w_cnt[2*i+1] | CNT_W'(32'd1 << (k-1)));
      end
    end
  end

  assign o_cnt = g_lvl[CNT_W].w_cnt[0];
endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 adder/subtractor: align, add/sub, normalise/round.
// One global advance signal moves every stage, giving full backpressure.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input logic              clk,
  input logic              rstn,
  fp_addsub_pipe_if.slave  bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int XW  = MAN_W + 4;          // hidden, fraction, G, R, S
  localparam int SW  = MAN_W + 5;          // XW plus carry
  localparam int EW  = EXP_W + 1;          // exponent with overflow headroom
  localparam int SHW = $clog2(XW);
  localparam int LZW = $clog2(XW + 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [XW-1:0]    win;
    logic [XW-1:0]    los;
    fp_special_e      sp;
    fp_flags_t        flags;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sum;
    fp_special_e      sp;
    fp_flags_t        flags;
    logic [TAG_W-1:0] tag;
  } s2_t;

  function automatic fp_class_e cls_of(input logic [W-1:0] x);
    return fp_classify(x[W-2:MAN_W] == '0, &x[W-2:MAN_W], x[MAN_W-1:0] == '0, x[MAN_W-1]);
  endfunction

  logic w_adv;
  logic r_v1, r_v2, r_out_valid;
  s1_t  r_s1, w_s1;
  s2_t  r_s2, w_s2;
  logic [W-1:0]     r_out_result, w_res;
  logic [TAG_W-1:0] r_out_tag;
  fp_flags_t        r_out_flags, w_flags;

  assign w_adv        = ~r_out_valid | bus.out_ready;
  assign bus.in_ready = w_adv;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_tag    = r_out_tag;
  assign bus.out_flags  = r_out_flags;

  // Stage 1 (align): classify, pick the larger magnitude, shift the other with sticky.
  fp_class_e w_a_cls, w_b_cls;
  logic w_a_sign, w_b_sign, w_swap, w_a_nan, w_b_nan;
  logic [W-2:0]       w_win_x, w_los_x;
  logic [EXP_W-1:0]   w_win_exp, w_los_exp, w_diff;
  logic [SHW-1:0]     w_sh;
  logic [XW-1:0]      w_los_man;
  logic [2*XW-1:0]    w_wide;
  always_comb begin
    w_s1      = '0;
    w_a_cls   = cls_of(bus.in_a);
    w_b_cls   = cls_of(bus.in_b);
    w_a_sign  = bus.in_a[W-1];
    w_b_sign  = bus.in_b[W-1] ^ bus.in_sub;
    w_a_nan   = (w_a_cls == FP_QNAN) || (w_a_cls == FP_SNAN);
    w_b_nan   = (w_b_cls == FP_QNAN) || (w_b_cls == FP_SNAN);
    w_swap    = bus.in_b[W-2:0] > bus.in_a[W-2:0];
    w_win_x   = w_swap ? bus.in_b[W-2:0] : bus.in_a[W-2:0];
    w_los_x   = w_swap ? bus.in_a[W-2:0] : bus.in_b[W-2:0];
    // Subnormals and zero sit at exponent 1 with a clear hidden bit.
    w_win_exp = (w_win_x[W-2:MAN_W] == '0) ? EXP_W'(1) : w_win_x[W-2:MAN_W];
    w_los_exp = (w_los_x[W-2:MAN_W] == '0) ? EXP_W'(1) : w_los_x[W-2:MAN_W];
    w_diff    = w_win_exp - w_los_exp;
    w_sh      = (32'(w_diff) >= 32'(MAN_W + 3)) ? SHW'(MAN_W + 3) : SHW'(w_diff);
    w_los_man = {w_los_x[W-2:MAN_W] != '0, w_los_x[MAN_W-1:0], 3'b000};
    w_wide    = {w_los_man, {XW{1'b0}}} >> w_sh;
    w_s1.win     = {w_win_x[W-2:MAN_W] != '0, w_win_x[MAN_W-1:0], 3'b000};
    w_s1.los     = {w_wide[2*XW-1:XW+1], w_wide[XW] | (|w_wide[XW-1:0])};
    w_s1.exp     = w_win_exp;
    w_s1.sign    = w_swap ? w_b_sign : w_a_sign;
    w_s1.eff_sub = w_a_sign ^ w_b_sign;
    w_s1.tag     = bus.in_tag;
    if (w_a_nan || w_b_nan) begin
      w_s1.sp            = SP_QNAN;
      w_s1.flags.invalid = (w_a_cls == FP_SNAN) || (w_b_cls == FP_SNAN);
    end else if ((w_a_cls == FP_INF) && (w_b_cls == FP_INF) && (w_a_sign != w_b_sign)) begin
      w_s1.sp            = SP_QNAN;
      w_s1.flags.invalid = 1'b1;
    end else if (w_a_cls == FP_INF) begin
      w_s1.sp   = SP_INF;
      w_s1.sign = w_a_sign;
    end else if (w_b_cls == FP_INF) begin
      w_s1.sp   = SP_INF;
      w_s1.sign = w_b_sign;
    end else begin
      w_s1.sp = SP_NONE;
    end
  end

  // Stage 2 (calculate): winner magnitude is never below the aligned loser.
  always_comb begin
    w_s2         = '0;
    w_s2.sign    = r_s1.sign;
    w_s2.eff_sub = r_s1.eff_sub;
    w_s2.exp     = r_s1.exp;
    w_s2.sp      = r_s1.sp;
    w_s2.flags   = r_s1.flags;
    w_s2.tag     = r_s1.tag;
    if (r_s1.eff_sub) w_s2.sum = {1'b0, r_s1.win} - {1'b0, r_s1.los};
    else              w_s2.sum = {1'b0, r_s1.win} + {1'b0, r_s1.los};
  end

  logic [LZW-1:0] w_lz, w_lsh;
  fp_lzc #(.WIDTH(XW)) u_lzc (.i_data(r_s2.sum[XW-1:0]), .o_cnt(w_lz));

  // Stage 3 (normalise/round): shift, round-to-nearest-even, apply specials.
  logic [EW-1:0]    w_exp_x, w_lim, w_nexp, w_fexp;
  logic [XW-1:0]    w_norm;
  logic [MAN_W+1:0] w_rmant;
  logic [MAN_W-1:0] w_ffrac;
  logic             w_rup, w_inexact, w_sign;
  always_comb begin
    w_exp_x = {1'b0, r_s2.exp};
    w_lim   = w_exp_x - EW'(1);
    w_lsh   = (32'(w_lz) > 32'(w_lim)) ? LZW'(w_lim) : w_lz;
    if (r_s2.sum[SW-1]) begin
      w_norm = {r_s2.sum[SW-1:2], r_s2.sum[1] | r_s2.sum[0]};
      w_nexp = w_exp_x + EW'(1);
    end else begin
      w_norm = r_s2.sum[XW-1:0] << w_lsh;
      w_nexp = w_exp_x - EW'(w_lsh);
    end
    w_rup     = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_inexact = |w_norm[2:0];
    w_rmant   = {1'b0, w_norm[XW-1:3]} + (MAN_W+2)'(w_rup);
    if (w_rmant[MAN_W+1]) begin
      w_fexp  = w_nexp + EW'(1);
      w_ffrac = w_rmant[MAN_W:1];
    end else if (w_rmant[MAN_W]) begin
      w_fexp  = w_nexp;
      w_ffrac = w_rmant[MAN_W-1:0];
    end else begin
      w_fexp  = '0;
      w_ffrac = w_rmant[MAN_W-1:0];
    end
    // Exact cancellation gives +0; like-signed zeros keep their sign.
    w_sign  = ((w_rmant == '0) && r_s2.eff_sub) ? 1'b0 : r_s2.sign;
    w_res   = '0;
    w_flags = '0;
    case (r_s2.sp)
      SP_QNAN: begin
        w_res         = QNAN;
        w_flags.invalid = r_s2.flags.invalid;
      end
      SP_INF: begin
        w_res = {r_s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
      default: begin
        if (w_fexp >= {1'b0, {EXP_W{1'b1}}}) begin
          w_res            = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          w_flags.overflow = 1'b1;
          w_flags.inexact  = 1'b1;
        end else begin
          w_res           = {w_sign, w_fexp[EXP_W-1:0], w_ffrac};
          w_flags.inexact = w_inexact;
        end
      end
    endcase
  end

  // Stage registers: all advance together; bubbles travel like operations.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_s1 <= '0;
      r_s2 <= '0;
    end else if (w_adv) begin
      r_v1 <= bus.in_valid;
      r_s1 <= w_s1;
      r_v2 <= r_v1;
      r_s2 <= w_s2;
    end
  end

  // Output register: holds its contents while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      r_out_flags  <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_v2;
      if (r_v2) begin
        r_out_result <= w_res;
        r_out_tag    <= r_s2.tag;
        r_out_flags  <= w_flags;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (FP32 configuration).
module tb_fp_addsub_pipe;
  import fp_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

  fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();
  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [3:0]  tag;
    logic [31:0] res;
    logic [2:0]  flg;
    bit          lat;
  } op_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [2:0]  flg;
    bit          lat;
    int          acc;
  } exp_t;

  op_t  pend[$];
  exp_t sb[$];
  bit          held = 1'b0;
  logic [31:0] h_res;
  logic [3:0]  h_tag;
  logic [2:0]  h_flg;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic add_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [3:0] tag, input logic [31:0] res, input logic [2:0] flg,
                        input bit lat);
    op_t o;
    o.a = a; o.b = b; o.sub = sub; o.tag = tag; o.res = res; o.flg = flg; o.lat = lat;
    pend.push_back(o);
  endtask

  // Exact FP32 encoding of a small integer.
  function automatic logic [31:0] i2f(input int n);
    logic [31:0] m;
    int          p;
    logic        s;
    if (n == 0) return 32'h0;
    s = (n < 0);
    m = s ? -n : n;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return {s, 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  // One clock: check holds, drive, check handshake, score outputs, record accepts.
  task automatic step(input int mode);
    exp_t e;
    op_t  o;
    @(negedge clk);
    if (held) begin
      check_val("hold_valid", bus.out_valid, 1);
      check_val("hold_result", bus.out_result, h_res);
      check_val("hold_tag", bus.out_tag, h_tag);
      check_val("hold_flags", bus.out_flags, h_flg);
    end
    case (mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
    if (pend.size() > 0) begin
      o = pend[0];
      bus.in_valid = 1'b1;
      bus.in_a     = o.a;
      bus.in_b     = o.b;
      bus.in_sub   = o.sub;
      bus.in_tag   = o.tag;
    end else begin
      bus.in_valid = 1'b0;
    end
    #1;
    check_val("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
    held = 1'b0;
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        check_val("spurious_out", bus.out_valid, 0);
      end else if (bus.out_ready) begin
        e = sb.pop_front();
        check_val("result", bus.out_result, e.res);
        check_val("tag", bus.out_tag, e.tag);
        check_val("flags", bus.out_flags, e.flg);
        if (e.lat) check_val("latency", cyc - e.acc, 3);
      end else begin
        held  = 1'b1;
        h_res = bus.out_result;
        h_tag = bus.out_tag;
        h_flg = bus.out_flags;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      o     = pend.pop_front();
      e.res = o.res; e.tag = o.tag; e.flg = o.flg; e.lat = o.lat; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic run_until_idle(input int mode, input int budget);
    int n = 0;
    while ((pend.size() > 0 || sb.size() > 0) && n < budget) begin
      step(mode);
      n++;
    end
    check_val("drain_timeout", pend.size() + sb.size(), 0);
  endtask

  initial begin
    int a_i, b_i;
    logic s;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0; bus.in_tag = '0;
    bus.out_ready = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_result", bus.out_result, 0);
    check_val("rst_out_tag", bus.out_tag, 0);
    check_val("rst_out_flags", bus.out_flags, 0);
    rstn = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", bus.in_ready, 1);

    // Directed values and boundaries, consumer always ready.
    add_op(32'h3F800000, 32'h40000000, 1'b0, 4'd5,  32'h40400000, 3'b000, 1'b1);
    add_op(32'h3F800000, 32'h3F800000, 1'b1, 4'd1,  32'h00000000, 3'b000, 1'b1);
    add_op(32'h00000001, 32'h00000001, 1'b0, 4'd2,  32'h00000002, 3'b000, 1'b1);
    add_op(32'h7F800000, 32'hFF800000, 1'b0, 4'd3,  32'h7FC00000, 3'b100, 1'b1);
    add_op(32'h7F800001, 32'h3F800000, 1'b0, 4'd4,  32'h7FC00000, 3'b100, 1'b1);
    add_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd6,  32'h7F800000, 3'b011, 1'b1);
    add_op(32'h3F800000, 32'h33800000, 1'b0, 4'd7,  32'h3F800000, 3'b001, 1'b1);
    add_op(32'h3F800001, 32'h33800000, 1'b0, 4'd8,  32'h3F800002, 3'b001, 1'b1);
    add_op(32'h80000000, 32'h80000000, 1'b0, 4'd9,  32'h80000000, 3'b000, 1'b1);
    add_op(32'h80000000, 32'h00000000, 1'b1, 4'd10, 32'h80000000, 3'b000, 1'b1);
    add_op(32'h00000000, 32'h80000000, 1'b0, 4'd11, 32'h00000000, 3'b000, 1'b1);
    add_op(32'h3F800000, 32'h7F800000, 1'b1, 4'd12, 32'hFF800000, 3'b000, 1'b1);
    add_op(32'h7FC00000, 32'h00000000, 1'b0, 4'd13, 32'h7FC00000, 3'b000, 1'b1);
    add_op(32'h7F800000, 32'h7F800000, 1'b1, 4'd14, 32'h7FC00000, 3'b100, 1'b1);
    add_op(32'h00800000, 32'h00000001, 1'b1, 4'd15, 32'h007FFFFF, 3'b000, 1'b1);
    run_until_idle(0, 100);

    // Back-to-back stream of exact integer sums with a random consumer.
    for (int i = 0; i < 16; i++) begin
      a_i = int'($urandom_range(0, 1000));
      b_i = int'($urandom_range(0, 1000));
      s   = 1'($urandom_range(0, 1));
      add_op(i2f(a_i), i2f(b_i), s, 4'(i), i2f(s ? a_i - b_i : a_i + b_i), 3'b000, 1'b0);
    end
    run_until_idle(1, 500);

    // Reset with three operations in flight behind a stalled output.
    add_op(i2f(1), i2f(2), 1'b0, 4'd1, i2f(3), 3'b000, 1'b0);
    add_op(i2f(5), i2f(2), 1'b1, 4'd2, i2f(3), 3'b000, 1'b0);
    add_op(i2f(7), i2f(7), 1'b0, 4'd3, i2f(14), 3'b000, 1'b0);
    repeat (4) step(2);
    check_val("stall_valid", bus.out_valid, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_val("rst2_out_valid", bus.out_valid, 0);
    check_val("rst2_out_result", bus.out_result, 0);
    check_val("rst2_in_ready", bus.in_ready, 1);
    sb.delete();
    pend.delete();
    held = 1'b0;
    repeat (6) step(0);
    add_op(32'h40A00000, 32'h3F800000, 1'b1, 4'd9, 32'h40800000, 3'b000, 1'b1);
    run_until_idle(0, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
